// File: rtl/dphy_pkg.sv
// dphy_pkg -- shared definitions for the D-PHY HS data-lane transmitter.
//   state_t     : lane sequencer states (IDLE .. EXIT)
//   SYNC_BYTE   : HS leader sequence byte, shifted out LSB first
//   LP_*        : low-power line levels {Dp,Dn}
//   CNT_W       : width of the per-state cycle counter (timing parameters < 256)
//   trail_dout(): HS-trail pattern derived from the final transmitted HS bit
package dphy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LP01,
      ST_LP00,
      ST_HS_ZERO,
      ST_SYNC,
      ST_DATA,
      ST_TRAIL,
      ST_EXIT
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   localparam logic [1:0] LP_11 = 2'b11;
   localparam logic [1:0] LP_01 = 2'b01;
   localparam logic [1:0] LP_00 = 2'b00;

   localparam int unsigned CNT_W = 8;

   // HS-trail holds the differential line at the opposite of the last bit sent.
   function automatic logic [1:0] trail_dout(input logic final_bit);
      return {2{~final_bit}};
   endfunction

endpackage

// File: rtl/dphy_tx_lane_if.sv
// dphy_tx_lane_if -- byte-stream handshake feeding the HS data lane.
//   tx_valid : a byte is offered (held until accepted)
//   tx_data  : payload byte
//   tx_last  : offered byte ends the burst
//   tx_ready : byte is taken this cycle
// Modports: master = byte source, slave = lane transmitter.
interface dphy_tx_lane_if;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output tx_valid,
      output tx_data,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      input  tx_last,
      output tx_ready
   );

endinterface

// File: rtl/dphy_tx_shifter.sv
// dphy_tx_shifter -- 8-bit load / shift-by-2 register with 4-slot phase counter.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : load load_data and restart the slot at phase 0 (wins over shift)
//   load_data  : byte to load
//   shift_en   : advance one 2-bit slot phase
//   dout       : current 2-bit HS symbol, dout[0] sent first
//   phase      : slot phase 0..3 of the byte in the register
//   final_bit  : second bit of the most recently shifted-out symbol
import dphy_pkg::*;

module dphy_tx_shifter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       shift_en,
   output logic [1:0] dout,
   output logic [1:0] phase,
   output logic       final_bit
);

   logic [7:0] sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr        <= '0;
         phase     <= '0;
         final_bit <= 1'b0;
      end else begin
         // Captured on every shifted symbol so HS-trail knows the last bit on the wire.
         if (shift_en)
            final_bit <= sr[1];
         if (load) begin
            sr    <= load_data;
            phase <= '0;
         end else if (shift_en) begin
            sr    <= {2'b00, sr[7:2]};
            phase <= phase + 2'd1;
         end
      end
   end

   assign dout = sr[1:0];

endmodule

// File: rtl/dphy_tx_lane.sv
// dphy_tx_lane -- MIPI D-PHY HS data-lane transmit sequencer.
//   Sequence: IDLE -> LP01 -> LP00 -> HS_ZERO -> SYNC -> DATA -> TRAIL -> EXIT -> IDLE
// Parameters: LPX_CYCLES, PREPARE_CYCLES, ZERO_CYCLES, TRAIL_CYCLES, EXIT_CYCLES
//   (durations in dphy_clk cycles, each 1..255).
// Ports:
//   dphy_clk  : single clock, all logic on rising edge
//   reset     : synchronous active-high reset
//   tx_valid / tx_data / tx_last / tx_ready : byte handshake (see dphy_tx_lane_if)
//   dout      : HS bits to DDR primitive, dout[0] first
//   hs_oe     : HS driver enable
//   lp_out    : LP levels {Dp,Dn}
//   busy      : state is not IDLE
//   underrun  : one-cycle pulse when no byte is offered at a ready slot
// Build option: define DPHY_TX_REG_OUTPUT_EN to add one register stage on
//   dout, hs_oe and lp_out (tx_ready, busy, underrun stay combinational).
import dphy_pkg::*;

module dphy_tx_lane #(
   parameter int unsigned LPX_CYCLES     = 4,
   parameter int unsigned PREPARE_CYCLES = 4,
   parameter int unsigned ZERO_CYCLES    = 12,
   parameter int unsigned TRAIL_CYCLES   = 8,
   parameter int unsigned EXIT_CYCLES    = 8
) (
   input  logic       dphy_clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [1:0] dout,
   output logic       hs_oe,
   output logic [1:0] lp_out,
   output logic       busy,
   output logic       underrun
);

   localparam logic [CNT_W-1:0] LPX_END     = CNT_W'(LPX_CYCLES - 1);
   localparam logic [CNT_W-1:0] PREPARE_END = CNT_W'(PREPARE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ZERO_END    = CNT_W'(ZERO_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRAIL_END   = CNT_W'(TRAIL_CYCLES - 1);
   localparam logic [CNT_W-1:0] EXIT_END    = CNT_W'(EXIT_CYCLES - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             last_q;      // byte currently in the shifter ends the burst

   logic             sh_load;
   logic [7:0]       sh_load_data;
   logic             sh_shift;
   logic [1:0]       sh_dout;
   logic [1:0]       sh_phase;
   logic             sh_final_bit;

   logic             accept;
   logic             clr_last;
   logic [1:0]       dout_c;
   logic             hs_oe_c;
   logic [1:0]       lp_out_c;

   dphy_tx_shifter u_shifter (
      .clk       (dphy_clk),
      .reset     (reset),
      .load      (sh_load),
      .load_data (sh_load_data),
      .shift_en  (sh_shift),
      .dout      (sh_dout),
      .phase     (sh_phase),
      .final_bit (sh_final_bit)
   );

   always_ff @(posedge dphy_clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         last_q <= 1'b0;
      end else begin
         state <= state_nx;
         // Counter restarts on every state change so each timed state sees 0..N-1.
         if (state_nx != state || state == ST_IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (accept)
            last_q <= tx_last;
         else if (clr_last)
            last_q <= 1'b0;
      end
   end

   always_comb begin
      state_nx     = state;
      tx_ready     = 1'b0;
      underrun     = 1'b0;
      accept       = 1'b0;
      clr_last     = 1'b0;
      sh_load      = 1'b0;
      sh_load_data = SYNC_BYTE;
      sh_shift     = 1'b0;
      dout_c       = 2'b00;
      hs_oe_c      = 1'b0;
      lp_out_c     = LP_00;

      unique case (state)
         ST_IDLE: begin
            lp_out_c = LP_11;
            if (tx_valid)
               state_nx = ST_LP01;
         end
         ST_LP01: begin
            lp_out_c = LP_01;
            if (cnt == LPX_END)
               state_nx = ST_LP00;
         end
         ST_LP00: begin
            // HS driver turns on only in the final prepare cycle.
            hs_oe_c = (cnt == PREPARE_END);
            if (cnt == PREPARE_END)
               state_nx = ST_HS_ZERO;
         end
         ST_HS_ZERO: begin
            hs_oe_c = 1'b1;
            if (cnt == ZERO_END) begin
               state_nx     = ST_SYNC;
               sh_load      = 1'b1;
               sh_load_data = SYNC_BYTE;
               clr_last     = 1'b1;
            end
         end
         ST_SYNC, ST_DATA: begin
            hs_oe_c  = 1'b1;
            sh_shift = 1'b1;
            dout_c   = sh_dout;
            // Slot boundary: take the next byte, or close the burst after
            // this slot (last byte sent, or nothing offered = underrun).
            if (sh_phase == 2'd3) begin
               if (!last_q) begin
                  tx_ready = 1'b1;
                  if (tx_valid) begin
                     accept       = 1'b1;
                     sh_load      = 1'b1;
                     sh_load_data = tx_data;
                     state_nx     = ST_DATA;
                  end else begin
                     underrun = 1'b1;
                     state_nx = ST_TRAIL;
                  end
               end else begin
                  state_nx = ST_TRAIL;
               end
            end
         end
         ST_TRAIL: begin
            hs_oe_c = 1'b1;
            dout_c  = trail_dout(sh_final_bit);
            if (cnt == TRAIL_END)
               state_nx = ST_EXIT;
         end
         ST_EXIT: begin
            lp_out_c = LP_11;
            if (cnt == EXIT_END)
               state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

`ifdef DPHY_TX_REG_OUTPUT_EN
   always_ff @(posedge dphy_clk) begin
      if (reset) begin
         dout   <= 2'b00;
         hs_oe  <= 1'b0;
         lp_out <= LP_11;
      end else begin
         dout   <= dout_c;
         hs_oe  <= hs_oe_c;
         lp_out <= lp_out_c;
      end
   end
`else
   assign dout   = dout_c;
   assign hs_oe  = hs_oe_c;
   assign lp_out = lp_out_c;
`endif

endmodule
